// File: rtl/nx_pkg.sv
// nx_pkg: shared typedefs for the nx mesh design.
//   nx_seq_state_t - state encoding of nx_mesh_sequencer.
package nx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    TRIGGER,
    WAIT,
    DONE
  } nx_seq_state_t;

endpackage

// File: rtl/nx_mesh_sequencer.sv
// nx_mesh_sequencer: issues single-cycle trigger pulses to an nx_mesh once
// the mesh has been continuously idle for SETTLE_CYCLES, repeating for a
// host-requested number of evaluations. Supports abort (drains through a
// final settle) and a per-SETTLE-phase watchdog.
//
// Ports:
//   clk_i, rst_ni        - clock, synchronous active-low reset
//   start_i, stop_i      - host run request / abort request
//   cycles_i             - trigger count, captured on an accepted start
//   busy_o, done_o       - not-IDLE flag / one-cycle completion pulse
//   error_o              - sticky watchdog flag, cleared on next start
//   cycle_count_o        - triggers issued in the current or last run
//   mesh_trigger_o       - to nx_mesh.trigger_i
//   mesh_idle_i          - from nx_mesh.idle_o
module nx_mesh_sequencer
  import nx_pkg::*;
#(
  parameter int unsigned CYCLE_WIDTH   = 32,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [CYCLE_WIDTH-1:0] cycles_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [CYCLE_WIDTH-1:0] cycle_count_o,
  output logic                   mesh_trigger_o,
  input  logic                   mesh_idle_i
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned WW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  // Transition is taken on the cycle whose idle sample completes the window,
  // i.e. when the counter still holds SETTLE_CYCLES-1.
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT - 1);

  nx_seq_state_t state_q, state_d;

  logic [SW-1:0]          settle_q;
  logic [WW-1:0]          wd_q;
  logic [CYCLE_WIDTH-1:0] target_q;
  logic [CYCLE_WIDTH-1:0] count_q;
  logic                   stop_pend_q;
  logic                   error_q;

  logic start_ok;
  logic settle_hit;
  logic wd_hit;
  logic stop_seen;
  logic in_run;

  assign start_ok   = start_i && !stop_i;
  assign settle_hit = mesh_idle_i && (settle_q == SETTLE_LAST);
  assign wd_hit     = (TIMEOUT != 0) && (wd_q == WD_LAST);
  // A stop arriving on the very cycle the window completes still blocks the trigger.
  assign stop_seen  = stop_pend_q || stop_i;
  assign in_run     = (state_q == SETTLE) || (state_q == TRIGGER) || (state_q == WAIT);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = SETTLE;
      end
      SETTLE: begin
        if (wd_hit) begin
          state_d = DONE;
        end else if (settle_hit) begin
          state_d = ((count_q < target_q) && !stop_seen) ? TRIGGER : DONE;
        end
      end
      TRIGGER: state_d = WAIT;
      WAIT:    state_d = SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of registered state
  always_comb begin
    busy_o         = (state_q != IDLE);
    done_o         = (state_q == DONE);
    mesh_trigger_o = (state_q == TRIGGER);
  end

  // Counters, run context and sticky flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      settle_q    <= '0;
      wd_q        <= '0;
      target_q    <= '0;
      count_q     <= '0;
      stop_pend_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      if (state_q == SETTLE) begin
        settle_q <= mesh_idle_i ? settle_q + SW'(1) : '0;
        if (TIMEOUT != 0) wd_q <= wd_q + WW'(1);
      end else begin
        settle_q <= '0;
        wd_q     <= '0;
      end

      if ((state_q == IDLE) && start_ok) begin
        target_q    <= cycles_i;
        count_q     <= '0;
        error_q     <= 1'b0;
        stop_pend_q <= 1'b0;
      end

      if (state_q == TRIGGER) count_q <= count_q + CYCLE_WIDTH'(1);

      if (in_run && stop_i) stop_pend_q <= 1'b1;

      if ((state_q == SETTLE) && wd_hit) error_q <= 1'b1;
    end
  end

  assign error_o       = error_q;
  assign cycle_count_o = count_q;

endmodule

// File: doc/nx_mesh_sequencer.md
# nx_mesh_sequencer

Host-side controller that sequences evaluation of an `nx_mesh` instance. It issues single-cycle `trigger` pulses to the mesh only once the mesh has been continuously idle for a programmable settle window, and repeats this for a host-requested number of evaluation cycles. It supports abort, detects hangs with a watchdog, and reports progress and completion to the host. It sits between the host control registers and the mesh `trigger_i` / `idle_o` pins; the data streams bypass it.

## Interface
Parameters:
- `CYCLE_WIDTH`, 32: width of the requested-cycle and completed-cycle counts.
- `SETTLE_CYCLES`, 2: consecutive idle cycles required before a trigger; legal range ≥1.
- `TIMEOUT`, 1024: maximum cycles spent in one SETTLE phase before error; 0 disables the watchdog.

Ports:
- Clock and reset:
  - `clk_i`, in, 1: the single clock.
  - `rst_ni`, in, 1: reset, synchronous and active-low.
- Host control:
  - `start_i`, in, 1: begin a run; sampled only in IDLE.
  - `stop_i`, in, 1: abort request.
  - `cycles_i`, in, CYCLE_WIDTH: number of triggers to issue; captured on an accepted start.
  - `busy_o`, out, 1: high in every state except IDLE.
  - `done_o`, out, 1: one-cycle completion pulse.
  - `error_o`, out, 1: sticky watchdog flag; cleared by the next accepted start.
  - `cycle_count_o`, out, CYCLE_WIDTH: triggers issued in the current or last run.
- Mesh:
  - `mesh_trigger_o`, out, 1: drives `nx_mesh.trigger_i`.
  - `mesh_idle_i`, in, 1: from `nx_mesh.idle_o`.

## Operation
- States:
  - IDLE: waiting for a start.
  - SETTLE: waiting for the mesh to be idle for the settle window.
  - TRIGGER: `mesh_trigger_o` is high in this state only.
  - WAIT: one-cycle blanking after a trigger; `mesh_idle_i` is ignored.
  - DONE: `done_o` is high in this state only.
- IDLE:
  - Start with `stop_i` low: capture `cycles_i` into the target count, clear `cycle_count_o` and `error_o`, then go to SETTLE.
  - Start and stop together: stop wins; the start is ignored.
- Start with `cycles_i`=0: SETTLE, then DONE. No trigger is issued.
- SETTLE:
  - The settle counter increments on each cycle `mesh_idle_i` is high and resets to 0 on any low cycle.
  - When it reaches SETTLE_CYCLES, go to TRIGGER if `cycle_count_o` < target and no stop is pending; otherwise go to DONE.
- TRIGGER: `cycle_count_o` increments by 1; next state is WAIT.
- WAIT: next state is SETTLE; the settle counter is cleared.
- `stop_i` in SETTLE, TRIGGER or WAIT:
  - Sets a stop-pending flag.
  - No further trigger is issued.
  - The run ends through a normal final settle, so in-flight messages drain.
- `stop_i` in DONE or IDLE: no effect.
- Watchdog:
  - Counts cycles in the current SETTLE phase.
  - When TIMEOUT>0 and the count reaches TIMEOUT, set `error_o` and go to DONE immediately.
- `cycle_count_o` holds its value after DONE until the next accepted start.
- The counter does not wrap; the target bounds it.

## Timing
- Reset values: state IDLE; all outputs 0 (`busy_o`, `done_o`, `error_o`, `mesh_trigger_o`, `cycle_count_o`). Internal counters and the stop-pending flag are 0.
- Reset mid-run: `mesh_trigger_o` falls on the reset edge; no done pulse is generated.
- All outputs are registers or decodes of registered state. There is no combinational path from any input to any output.
- Start accepted at edge 0: `busy_o` is high from cycle 1, state SETTLE.
- With `mesh_idle_i` constantly high:
  - The first trigger is in cycle SETTLE_CYCLES+1.
  - Subsequent triggers come every SETTLE_CYCLES+2 cycles.
- After the final trigger: WAIT, then a full settle, then DONE for one cycle, then IDLE (`busy_o` low) the next cycle.
- A low pulse on `mesh_idle_i` at any point in SETTLE restarts the settle window.

## Structure
- Package `nx_pkg`, shared with the rest of the design: the state enum typedef `nx_seq_state_t` (IDLE, SETTLE, TRIGGER, WAIT, DONE).
- Single module; no sub-module. The settle counter and watchdog counter are small inline counters.
- Settle counter width: `$clog2(SETTLE_CYCLES+1)`.
- Watchdog counter width: `$clog2(TIMEOUT+1)`, minimum 1.

## Test plan
- SETTLE_CYCLES=2, `mesh_idle_i`=1, start with `cycles_i`=3 at cycle 0:
  - Triggers in cycles 3, 7 and 11.
  - `done_o` in cycle 15; `busy_o` low from cycle 16; `cycle_count_o`=3.
- Start with `cycles_i`=0: no trigger; `done_o` in cycle 3; `cycle_count_o`=0.
- Idle toggling, `cycles_i`=1, idle low cycles 1–4, high from cycle 5:
  - Trigger in cycle 7.
  - An idle drop in cycle 9 delays `done_o` until 2 consecutive idle cycles follow.
- `cycles_i`=5, `stop_i` pulsed during the WAIT after trigger 2: no third trigger; `done_o` after the final settle; `cycle_count_o`=2; `error_o`=0.
- TIMEOUT=8, `mesh_idle_i` held at 0 after start: `done_o` and `error_o` asserted 9 cycles after the start edge; `error_o` clears on the next start.
- Reset asserted during TRIGGER of a 4-cycle run:
  - All outputs are 0 the next cycle; no `done_o` pulse.
  - A new start after reset behaves like the first scenario.
- Start with stop in the same cycle while IDLE: `busy_o` stays 0 and no trigger is issued.
